// File: rtl/pla_1588_xgmii_pkg.sv
// pla_1588_xgmii_pkg: XGMII control codes, preamble word and frame-check FSM encoding.
package pla_1588_xgmii_pkg;
  localparam logic [7:0]  XGMII_S   = 8'hFB;
  localparam logic [7:0]  XGMII_T   = 8'hFD;
  localparam logic [7:0]  XGMII_I   = 8'h07;
  localparam logic [7:0]  XGMII_E   = 8'hFE;
  localparam logic [31:0] PREAMBLE  = 32'hD5555555;
  localparam logic [31:0] IDLE_WORD = {4{XGMII_I}};
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2} state_t;
  function automatic logic [13:0] sat_add14(input logic [13:0] a, input logic [2:0] b);
    logic [14:0] s;
    s = {1'b0, a} + {12'b0, b};
    return s[14] ? 14'h3FFF : s[13:0];
  endfunction
endpackage

// File: rtl/pla_1588_sat_cnt16.sv
// pla_1588_sat_cnt16: saturating event counter, clear has priority over increment.
module pla_1588_sat_cnt16 #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign o_cnt = r_cnt;
endmodule

// File: rtl/pla_1588_tx_frame_check.sv
// pla_1588_tx_frame_check: TX XGMII frame parser/classifier with 2-cycle pass-through.
// Define PLA_1588_TX_ERR_MARK_EN to stamp /E/ next to the /T/ of bad frames.
module pla_1588_tx_frame_check
  import pla_1588_xgmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        I_sys_312m_clk,
  input  logic        I_fpga_reset,
  input  logic [3:0]  I_gmii_txc,
  input  logic [31:0] I_gmii_data,
  input  logic [3:0]  I_cnt_clr,
  output logic [3:0]  O_gmii_txc,
  output logic [31:0] O_gmii_data,
  output logic [15:0] O_good_frame_num,
  output logic [15:0] O_runt_num,
  output logic [15:0] O_oversize_num,
  output logic [15:0] O_ctrl_err_num,
  output logic [13:0] O_frame_len,
  output logic        O_frame_len_vld,
  output logic [7:0]  O_state
);
  localparam logic [13:0] L_MIN = 14'(MIN_LEN);
  localparam logic [13:0] L_MAX = 14'(MAX_LEN);
  state_t      r_state;
  logic [13:0] r_len, r_frame_len;
  logic        r_err, r_frame_len_vld;
  logic [3:0]  r_txc1, r_txc2;
  logic [31:0] r_data1, r_data2;
  logic [1:0]  w_tk;
  logic        w_has_t, w_sof, w_in, w_restart, w_close, w_err, w_over, w_runt;
  logic [3:0]  w_before, w_txc1, w_txc2;
  logic [2:0]  w_nzero, w_add;
  logic [13:0] w_len;
  logic [31:0] w_data1, w_data2;
  logic        w_inc_good, w_inc_runt, w_inc_over, w_inc_ctl;
  always_comb begin
    w_has_t = 1'b0;
    w_tk = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (I_gmii_txc[i] && I_gmii_data[8*i +: 8] == XGMII_T) begin
        w_has_t = 1'b1;
        w_tk = 2'(i);
      end
  end
  // lanes preceding the first /T/ are the only ones whose control flags matter
  assign w_before  = w_has_t ? (4'b0001 << w_tk) - 4'b0001 : 4'hF;
  assign w_nzero   = 3'(!I_gmii_txc[0]) + 3'(!I_gmii_txc[1]) + 3'(!I_gmii_txc[2]) + 3'(!I_gmii_txc[3]);
  assign w_sof     = I_gmii_txc[0] && I_gmii_data[7:0] == XGMII_S;
  assign w_in      = r_state != S_IDLE;
  assign w_restart = w_in && w_sof;
  assign w_close   = w_restart || (w_in && w_has_t);
  assign w_add     = r_state == S_DATA ? (w_has_t ? {1'b0, w_tk} : w_nzero) : 3'd0;
  assign w_err     = w_restart || r_err
                   || (r_state == S_PRE && (I_gmii_txc != 4'h0 || I_gmii_data != PREAMBLE))
                   || (r_state == S_DATA && (I_gmii_txc & w_before) != 4'h0);
  assign w_len     = w_restart ? r_len : sat_add14(r_len, w_add);
  assign w_over    = w_len > L_MAX;
  assign w_runt    = w_len < L_MIN;
  assign w_inc_ctl  = w_close && w_err;
  assign w_inc_over = w_close && !w_err && w_over;
  assign w_inc_runt = w_close && !w_err && !w_over && w_runt;
  assign w_inc_good = w_close && !w_err && !w_over && !w_runt;
`ifdef PLA_1588_TX_ERR_MARK_EN
  logic w_bad;
  assign w_bad = w_close && !w_restart && (w_err || w_over || w_runt);
  // /T/ in lane 0 marks the last lane of the word already in stage 1
  always_comb begin
    w_txc1 = I_gmii_txc;
    w_data1 = I_gmii_data;
    w_txc2 = r_txc1;
    w_data2 = r_data1;
    for (int i = 0; i < 3; i++)
      if (w_bad && w_tk == 2'(i + 1)) begin
        w_txc1[i] = 1'b1;
        w_data1[8*i +: 8] = XGMII_E;
      end
    if (w_bad && w_tk == 2'd0) begin
      w_txc2[3] = 1'b1;
      w_data2[31:24] = XGMII_E;
    end
  end
`else
  assign w_txc1  = I_gmii_txc;
  assign w_data1 = I_gmii_data;
  assign w_txc2  = r_txc1;
  assign w_data2 = r_data1;
`endif
  always_ff @(posedge I_sys_312m_clk) begin
    if (I_fpga_reset) begin
      r_state <= S_IDLE;
      r_len <= '0;
      r_err <= 1'b0;
      r_frame_len <= '0;
      r_frame_len_vld <= 1'b0;
      r_txc1 <= 4'hF;
      r_txc2 <= 4'hF;
      r_data1 <= IDLE_WORD;
      r_data2 <= IDLE_WORD;
    end else begin
      r_txc1 <= w_txc1;
      r_txc2 <= w_txc2;
      r_data1 <= w_data1;
      r_data2 <= w_data2;
      r_frame_len_vld <= w_close;
      if (w_close) r_frame_len <= w_len;
      if (w_sof) begin
        r_state <= S_PRE;
        r_len <= '0;
        r_err <= 1'b0;
      end else if (w_in) begin
        r_state <= w_has_t ? S_IDLE : S_DATA;
        r_len <= w_len;
        r_err <= w_err;
      end
    end
  end
  pla_1588_sat_cnt16 u_good (.i_clk(I_sys_312m_clk), .i_rst(I_fpga_reset), .i_inc(w_inc_good), .i_clr(I_cnt_clr[0]), .o_cnt(O_good_frame_num));
  pla_1588_sat_cnt16 u_runt (.i_clk(I_sys_312m_clk), .i_rst(I_fpga_reset), .i_inc(w_inc_runt), .i_clr(I_cnt_clr[1]), .o_cnt(O_runt_num));
  pla_1588_sat_cnt16 u_over (.i_clk(I_sys_312m_clk), .i_rst(I_fpga_reset), .i_inc(w_inc_over), .i_clr(I_cnt_clr[2]), .o_cnt(O_oversize_num));
  pla_1588_sat_cnt16 u_ctl  (.i_clk(I_sys_312m_clk), .i_rst(I_fpga_reset), .i_inc(w_inc_ctl),  .i_clr(I_cnt_clr[3]), .o_cnt(O_ctrl_err_num));
  assign O_gmii_txc      = r_txc2;
  assign O_gmii_data     = r_data2;
  assign O_frame_len     = r_frame_len;
  assign O_frame_len_vld = r_frame_len_vld;
  assign O_state         = {5'd0, r_state != S_IDLE, r_state};
endmodule

// File: tb/tb_pla_1588_tx_frame_check.sv
// tb_pla_1588_tx_frame_check: directed frame table plus multi-cycle corner sequences.
module tb_pla_1588_tx_frame_check;
  localparam logic [31:0] IDLE = 32'h07070707;
  localparam logic [31:0] PRE  = 32'hD5555555;
  localparam logic [31:0] BPRE = 32'hD4555555;
`ifdef PLA_1588_TX_ERR_MARK_EN
  localparam bit MARK = 1'b1;
`else
  localparam bit MARK = 1'b0;
`endif
  typedef struct {
    int n;
    logic [31:0] pre;
    int g, r, o, c, len;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] txc = 4'hF, clr = 4'h0;
  logic [31:0] data = IDLE;
  logic [3:0] o_txc;
  logic [31:0] o_data;
  logic [15:0] good, runt, over, ctl;
  logic [13:0] o_len;
  logic o_vld;
  logic [7:0] o_state;
  logic sc_inc = 1'b0, sc_clr = 1'b0;
  logic [3:0] sc_cnt;
  int checks = 0, failures = 0;
  logic [35:0] hist[$], got[$];
  int vq[$];
  vec_t tv[10];
  always #5 clk = ~clk;
  pla_1588_tx_frame_check dut (
    .I_sys_312m_clk(clk), .I_fpga_reset(rst), .I_gmii_txc(txc), .I_gmii_data(data), .I_cnt_clr(clr),
    .O_gmii_txc(o_txc), .O_gmii_data(o_data), .O_good_frame_num(good), .O_runt_num(runt),
    .O_oversize_num(over), .O_ctrl_err_num(ctl), .O_frame_len(o_len), .O_frame_len_vld(o_vld), .O_state(o_state)
  );
  pla_1588_sat_cnt16 #(.W(4)) u_sc (.i_clk(clk), .i_rst(rst), .i_inc(sc_inc), .i_clr(sc_clr), .o_cnt(sc_cnt));
  task automatic chk(input string nm, input logic [35:0] a, input logic [35:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask
  task automatic cyc(input logic [3:0] c, input logic [31:0] d);
    txc = c;
    data = d;
    hist.push_back({c, d});
    @(posedge clk);
    #1;
    got.push_back({o_txc, o_data});
    if (o_vld) vq.push_back(int'(o_len));
  endtask
  task automatic restart_log();
    hist.delete();
    got.delete();
    vq.delete();
    hist.push_back({4'hF, IDLE});
  endtask
  task automatic frame(input int n, input logic [31:0] pre, input logic [3:0] c_clr, output int t);
    int k, w;
    logic [31:0] d;
    logic [3:0] c;
    k = n % 4;
    w = n / 4;
    d = IDLE;
    c = 4'hF;
    cyc(4'b0001, 32'h555555FB);
    cyc(4'b0000, pre);
    for (int i = 0; i < w; i++) cyc(4'b0000, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    for (int j = 0; j < k; j++) begin
      d[8*j +: 8] = 8'hA5;
      c[j] = 1'b0;
    end
    d[8*k +: 8] = 8'hFD;
    clr = c_clr;
    cyc(c, d);
    clr = 4'h0;
    t = hist.size() - 1;
  endtask
  task automatic cnts(input string nm, input int g, input int r, input int o, input int c);
    chk({nm, "_good"}, 36'(good), 36'(g));
    chk({nm, "_runt"}, 36'(runt), 36'(r));
    chk({nm, "_over"}, 36'(over), 36'(o));
    chk({nm, "_ctl"}, 36'(ctl), 36'(c));
  endtask
  initial begin
    int t;
    tv[0] = '{64,    PRE,  1, 0, 0, 0, 64};
    tv[1] = '{62,    PRE,  1, 1, 0, 0, 62};
    tv[2] = '{1530,  PRE,  1, 1, 1, 0, 1530};
    tv[3] = '{1522,  PRE,  2, 1, 1, 0, 1522};
    tv[4] = '{64,    BPRE, 2, 1, 1, 1, 64};
    tv[5] = '{63,    PRE,  2, 2, 1, 1, 63};
    tv[6] = '{65,    PRE,  3, 2, 1, 1, 65};
    tv[7] = '{16400, PRE,  3, 2, 2, 1, 16383};
    tv[8] = '{1523,  PRE,  3, 2, 3, 1, 1523};
    tv[9] = '{60,    PRE,  3, 3, 3, 1, 60};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    restart_log();
    chk("rst_txc", 36'(o_txc), 36'hF);
    chk("rst_data", 36'(o_data), 36'(IDLE));
    chk("rst_len", 36'(o_len), 36'd0);
    chk("rst_vld", 36'(o_vld), 36'd0);
    chk("rst_state", 36'(o_state), 36'd0);
    cnts("rst", 0, 0, 0, 0);
    for (int v = 0; v < 10; v++) begin
      int s, k, mi, perr;
      bit bad;
      logic [35:0] e;
      vq.delete();
      s = hist.size();
      frame(tv[v].n, tv[v].pre, 4'h0, t);
      cyc(4'hF, IDLE);
      cyc(4'hF, IDLE);
      cnts($sformatf("v%0d", v), tv[v].g, tv[v].r, tv[v].o, tv[v].c);
      chk($sformatf("v%0d_nvld", v), 36'(vq.size()), 36'd1);
      chk($sformatf("v%0d_len", v), 36'(vq.size() > 0 ? vq[0] : -1), 36'(tv[v].len));
      bad = v != 0 && v != 3 && v != 6;
      k = tv[v].n % 4;
      mi = k > 0 ? t : t - 1;
      perr = 0;
      for (int i = s; i <= t; i++) begin
        e = hist[i];
        if (MARK && bad && i == mi) begin
          e[32 + (k > 0 ? k - 1 : 3)] = 1'b1;
          e[8 * (k > 0 ? k - 1 : 3) +: 8] = 8'hFE;
        end
        if (got[i] !== e) perr++;
      end
      chk($sformatf("v%0d_passthru", v), 36'(perr), 36'd0);
    end
    vq.delete();
    frame(1530, PRE, 4'h0, t);
    frame(1522, PRE, 4'h0, t);
    cyc(4'hF, IDLE);
    cyc(4'hF, IDLE);
    cnts("b2b", 4, 3, 4, 1);
    chk("b2b_nvld", 36'(vq.size()), 36'd2);
    chk("b2b_len0", 36'(vq.size() > 1 ? vq[0] : -1), 36'd1530);
    chk("b2b_len1", 36'(vq.size() > 1 ? vq[1] : -1), 36'd1522);
    vq.delete();
    cyc(4'b0001, 32'h555555FB);
    chk("state_pre", 36'(o_state), 36'h05);
    cyc(4'b0000, PRE);
    repeat (5) cyc(4'b0000, 32'h12345678);
    chk("state_data", 36'(o_state), 36'h06);
    frame(64, PRE, 4'h0, t);
    cyc(4'hF, IDLE);
    cyc(4'hF, IDLE);
    chk("state_idle", 36'(o_state), 36'h00);
    cnts("midS", 5, 3, 4, 2);
    chk("midS_len0", 36'(vq.size() > 1 ? vq[0] : -1), 36'd20);
    chk("midS_len1", 36'(vq.size() > 1 ? vq[1] : -1), 36'd64);
    frame(64, PRE, 4'b0001, t);
    cyc(4'hF, IDLE);
    cyc(4'hF, IDLE);
    cnts("clr_inc", 0, 3, 4, 2);
    clr = 4'b0010;
    cyc(4'hF, IDLE);
    clr = 4'h0;
    cnts("clr_runt", 0, 0, 4, 2);
    cyc(4'b0001, 32'h555555FB);
    cyc(4'b0000, PRE);
    repeat (3) cyc(4'b0000, 32'hCAFEBABE);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_txc", 36'(o_txc), 36'hF);
    chk("rstmid_data", 36'(o_data), 36'(IDLE));
    chk("rstmid_state", 36'(o_state), 36'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    restart_log();
    cnts("rstmid", 0, 0, 0, 0);
    frame(64, PRE, 4'h0, t);
    cyc(4'hF, IDLE);
    cyc(4'hF, IDLE);
    cnts("after_rst", 1, 0, 0, 0);
    chk("after_rst_len", 36'(vq.size() == 1 ? vq[0] : -1), 36'd64);
    sc_inc = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sat_hold", 36'(sc_cnt), 36'hF);
    sc_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("sat_clr_wins", 36'(sc_cnt), 36'h0);
    sc_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_inc", 36'(sc_cnt), 36'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
